// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise and glitch-filter both phases, decode Gray-code
// quarter-steps, and emit one ENABLE pulse (with UPDN direction) per EDGES_PER_STEP steps.
module quad_step_decoder #(
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter int unsigned EDGES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       A_IN,
    input  logic       B_IN,
    input  logic       CLR,
    output logic       ENABLE,
    output logic       UPDN,
    output logic       ERR,
    output logic [1:0] PHASE
);
    localparam logic [7:0]        FiltLast = 8'(FILTER_CYCLES - 1);
    localparam logic signed [3:0] AccPos   = 4'(EDGES_PER_STEP - 1);
    localparam logic signed [3:0] AccNeg   = -AccPos;

    typedef enum logic {StInit, StTrack} state_e;

    logic [1:0]        s1_q, s2_q, filt_q, filt_d, upd;
    logic [7:0]        cnt_q [2];
    logic [7:0]        cnt_d [2];
    logic              idle;
    state_e            state_q;
    logic [1:0]        prev_q, delta;
    logic signed [3:0] acc_q;
    logic [7:0]        idle_cnt_q;

    function automatic logic [1:0] gray_idx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    always_comb begin
        filt_d = filt_q;
        upd    = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == FiltLast) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
                upd[i]    = 1'b1;
            end
        end
    end

    assign idle  = (cnt_q[0] == '0) && (cnt_q[1] == '0) && (s2_q == filt_q);
    // Modulo-4 distance along the forward sequence: 1 = +1, 3 = -1, 2 = both bits flipped.
    assign delta = gray_idx(filt_q) - gray_idx(prev_q);
    assign PHASE = filt_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            s1_q   <= {A_IN, B_IN};
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= StInit;
            prev_q     <= '0;
            acc_q      <= '0;
            idle_cnt_q <= '0;
            ENABLE     <= 1'b0;
            UPDN       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            ENABLE <= 1'b0;
            ERR    <= 1'b0;
            case (state_q)
                StInit: begin
                    // Seed prev with the value PHASE takes on this edge so entry never counts.
                    if ((|upd) || (idle && (idle_cnt_q == FiltLast))) begin
                        prev_q     <= filt_d;
                        idle_cnt_q <= '0;
                        state_q    <= StTrack;
                    end else if (idle) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                StTrack: begin
                    prev_q <= filt_q;
                    case (delta)
                        2'd1: begin
                            if (acc_q == AccPos) begin
                                acc_q <= '0;
                                if (!CLR) begin
                                    ENABLE <= 1'b1;
                                    UPDN   <= 1'b1;
                                end
                            end else begin
                                acc_q <= acc_q + 4'sd1;
                            end
                        end
                        2'd3: begin
                            if (acc_q == AccNeg) begin
                                acc_q <= '0;
                                if (!CLR) begin
                                    ENABLE <= 1'b1;
                                    UPDN   <= 1'b0;
                                end
                            end else begin
                                acc_q <= acc_q - 4'sd1;
                            end
                        end
                        2'd2: begin
                            ERR   <= 1'b1;
                            acc_q <= '0;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= StInit;
            endcase
            if (CLR) begin
                acc_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a default instance and an EDGES_PER_STEP=1 instance
// share the same A/B/CLR stimulus; vector table plus reset and glitch sequences.
module tb_quad_step_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_in = 1'b0, b_in = 1'b0, clr = 1'b0;
    logic       en4, up4, err4, en1, up1, err1;
    logic [1:0] ph4, ph1;

    int n_chk  = 0;
    int n_fail = 0;
    int ctr    = 0;

    typedef struct {
        logic a;
        logic b;
        int   hold;
        bit   clr_all;
        int   clr_edge;
        int   en4;
        int   err;
        int   en1;
        int   updn4;
        int   updn1;
        int   exp_ctr;
    } vec_t;

    vec_t vq[$];

    quad_step_decoder dut4 (
        .clk(clk), .RST(rst), .A_IN(a_in), .B_IN(b_in), .CLR(clr),
        .ENABLE(en4), .UPDN(up4), .ERR(err4), .PHASE(ph4)
    );

    quad_step_decoder #(.FILTER_CYCLES(4), .EDGES_PER_STEP(1)) dut1 (
        .clk(clk), .RST(rst), .A_IN(a_in), .B_IN(b_in), .CLR(clr),
        .ENABLE(en1), .UPDN(up1), .ERR(err1), .PHASE(ph1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic a, input logic b, input int hold, input bit ca,
                                input int ce, input int e4, input int er, input int e1,
                                input int u4, input int u1, input int ec);
        vec_t v;
        v = '{a, b, hold, ca, ce, e4, er, e1, u4, u1, ec};
        vq.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int c4 = 0, c1 = 0, ce4 = 0, ce1 = 0, first4 = -1, firsterr = -1;
        a_in = v.a;
        b_in = v.b;
        for (int k = 0; k < v.hold; k++) begin
            clr = v.clr_all || (k == v.clr_edge);
            @(posedge clk);
            @(negedge clk);
            clr = 1'b0;
            if (en4) begin
                c4++;
                if (first4 < 0) first4 = k;
            end
            if (en1) begin
                c1++;
                ctr += up1 ? 1 : -1;
            end
            if (err4) begin
                ce4++;
                if (firsterr < 0) firsterr = k;
            end
            if (err1) ce1++;
        end
        check($sformatf("v%0d en4 count", idx), c4, v.en4);
        check($sformatf("v%0d en1 count", idx), c1, v.en1);
        check($sformatf("v%0d err4 count", idx), ce4, v.err);
        check($sformatf("v%0d err1 count", idx), ce1, v.err);
        if (v.en4 > 0) check($sformatf("v%0d en4 edge", idx), first4, 6);
        if (v.err > 0) check($sformatf("v%0d err4 edge", idx), firsterr, 6);
        check($sformatf("v%0d updn4", idx), int'(up4), v.updn4);
        check($sformatf("v%0d updn1", idx), int'(up1), v.updn1);
        check($sformatf("v%0d phase4", idx), int'(ph4), int'({v.a, v.b}));
        check($sformatf("v%0d phase1", idx), int'(ph1), int'({v.a, v.b}));
        if (v.exp_ctr >= 0) check($sformatf("v%0d counter", idx), ctr, v.exp_ctr);
    endtask

    initial begin
        int bad, c4, c1, ce;
        bit moved;

        //  a  b  hold clrA clrE en4 err en1 u4 u1 ctr
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 0, -1);  // v0  11->01 reverse
        add(0, 0, 10, 0, -1, 0, 0, 1, 0, 0, -1);  // v1  01->00 reverse
        add(0, 0,  3, 1, -1, 0, 0, 0, 0, 0, -1);  // v2  CLR clears acc
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);  // v3  forward step begins
        add(1, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 0, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(0, 0, 10, 0, -1, 1, 0, 1, 1, 1, -1);  // v6  4th quarter-step: pulse up
        add(1, 0, 10, 0, -1, 0, 0, 1, 1, 0, -1);  // v7  reverse, counter from 5
        add(1, 1, 10, 0, -1, 0, 0, 1, 1, 0, -1);
        add(0, 1, 10, 0, -1, 0, 0, 1, 1, 0,  2);  // v9  counter reaches 2
        add(0, 0, 10, 0, -1, 1, 0, 1, 0, 0, -1);  // v10 4th reverse: pulse down
        add(1, 1, 10, 0, -1, 0, 1, 0, 0, 1, -1);  // v11 illegal 00->11
        add(0, 0, 10, 0, -1, 0, 1, 0, 0, 1, -1);  // v12 illegal 11->00
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);  // v13 acc=1
        add(1, 0, 10, 0, -1, 0, 1, 0, 0, 1, -1);  // v14 illegal clears acc
        add(0, 0, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);  // v17 acc=3, no pulse if cleared
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 0, -1);  // v18 reversal walks back
        add(0, 0, 10, 0, -1, 0, 0, 1, 0, 0, -1);
        add(0, 0,  2, 1, -1, 0, 0, 0, 0, 0, -1);  // v20 CLR
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 0, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(0, 0, 10, 0,  6, 0, 0, 0, 0, 1, -1);  // v24 CLR on the evaluating edge
        add(0, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 1, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(1, 0, 10, 0, -1, 0, 0, 1, 0, 1, -1);
        add(0, 0, 10, 0, -1, 1, 0, 1, 1, 1, -1);  // v28 one pulse after CLR

        // Reset held while the inputs toggle.
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_in = (k % 2) == 1;
            b_in = ((k / 2) % 2) == 1;
            if (en4 || up4 || err4 || (ph4 != 2'b00)) bad++;
            if (en1 || up1 || err1 || (ph1 != 2'b00)) bad++;
        end
        check("reset outputs zero", bad, 0);

        @(negedge clk);
        a_in = 1'b1;
        b_in = 1'b1;
        rst  = 1'b1;
        c4 = 0;
        ce = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            c4 += int'(en4) + int'(en1) + int'(up4) + int'(up1);
            ce += int'(err4) + int'(err1);
        end
        check("post-reset enable/updn", c4, 0);
        check("post-reset err", ce, 0);
        check("post-reset phase4", int'(ph4), 3);
        check("post-reset phase1", int'(ph1), 3);

        for (int i = 0; i <= 10; i++) begin
            if (i == 7) ctr = 5;
            run_vec(vq[i], i);
        end

        // 3-cycle glitch on A must be rejected.
        a_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_in = 1'b0;
        moved = 1'b0;
        c4 = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ph4 != 2'b00) moved = 1'b1;
            c4 += int'(en4) + int'(en1);
        end
        check("glitch3 phase moved", int'(moved), 0);
        check("glitch3 enables", c4, 0);

        // 4-cycle pulse on A passes the filter.
        a_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("glitch4 phase", int'(ph4), 2);
        c4 = 0;
        c1 = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            c4 += int'(en4);
            c1 += int'(en1);
        end
        check("glitch4 phase back", int'(ph4), 0);
        check("glitch4 en4", c4, 0);
        check("glitch4 en1", c1, 2);
        check("glitch4 updn1", int'(up1), 1);

        for (int i = 11; i < vq.size(); i++) begin
            run_vec(vq[i], i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
